cart_mem_arbiter: RTL

//  Shares the single cartridge backing-memory port (SDRAM-side MEM_* bus) between two requesters:
//  the A-bus cartridge slave (port CA) and the host ROM/RAM loader (port LD).

---
 rtl/cart_mem_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter
//   Shares the cartridge backing-memory port (MEM_*) between the A-bus cartridge
//   slave (CA) and the host ROM/RAM loader (LD). Round-robin arbitration, loader
//   exclusive lock and a stuck-transfer timeout; one transaction in flight.
//
// Ports
//   CLK, RST_N                    clock, asynchronous active-low reset
//   CA_A/CA_DO/CA_WE/CA_RD        cartridge request (address, wdata, byte WE, read)
//   CA_DI/CA_RDY                  cartridge read data, 1-cycle completion pulse
//   LD_A/LD_DO/LD_WE/LD_RD        loader request
//   LD_DI/LD_RDY                  loader read data, 1-cycle completion pulse
//   LOCK                          loader exclusive: blocks new CA grants
//   MEM_A/MEM_DO/MEM_WE/MEM_RD    memory request (registered)
//   MEM_DI/MEM_RDY                memory read data, 1-cycle completion pulse
//   TO_ERR                        sticky timeout flag
module cart_mem_arbiter #(
  parameter int unsigned AW      = 21,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW:1]   CA_A,
  input  logic [15:0]   CA_DO,
  input  logic [1:0]    CA_WE,
  input  logic          CA_RD,
  output logic [15:0]   CA_DI,
  output logic          CA_RDY,
  input  logic [AW:1]   LD_A,
  input  logic [15:0]   LD_DO,
  input  logic [1:0]    LD_WE,
  input  logic          LD_RD,
  output logic [15:0]   LD_DI,
  output logic          LD_RDY,
  input  logic          LOCK,
  output logic [AW:1]   MEM_A,
  output logic [15:0]   MEM_DO,
  output logic [1:0]    MEM_WE,
  output logic          MEM_RD,
  input  logic [15:0]   MEM_DI,
  input  logic          MEM_RDY,
  output logic          TO_ERR
);

  // Counter must hold the value TIMEOUT; keep at least one bit when disabled.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GNT_CA = 2'd1,
    S_GNT_LD = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_last_ld;
  logic            r_is_rd;
  logic [CW-1:0]   r_cnt;
  logic [AW:1]     r_mem_a;
  logic [15:0]     r_mem_do;
  logic [1:0]      r_mem_we;
  logic            r_mem_rd;
  logic [15:0]     r_ca_di;
  logic [15:0]     r_ld_di;
  logic            r_ca_rdy;
  logic            r_ld_rdy;
  logic            r_to_err;

  logic            w_ca_req;
  logic            w_ld_req;
  logic            w_ca_elig;
  logic            w_grant_ca;
  logic            w_grant_ld;
  logic            w_timeout;
  logic [15:0]     w_rd_data;

  // Request decode; LOCK removes CA from arbitration.
  assign w_ca_req  = CA_RD | (|CA_WE);
  assign w_ld_req  = LD_RD | (|LD_WE);
  assign w_ca_elig = w_ca_req & ~LOCK;

  // Round robin: with both eligible, CA wins only if LD was granted last.
  assign w_grant_ca = w_ca_elig & (~w_ld_req | r_last_ld);
  assign w_grant_ld = w_ld_req & ~w_grant_ca;

  // Timeout fires on the GNT cycle where the counter has reached TIMEOUT.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));

  // MEM_RDY takes precedence over a coincident timeout.
  assign w_rd_data = MEM_RDY ? MEM_DI : 16'hFFFF;

  // Arbiter FSM with registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_last_ld <= 1'b1;
      r_is_rd   <= 1'b0;
      r_cnt     <= '0;
      r_mem_a   <= '0;
      r_mem_do  <= 16'h0000;
      r_mem_we  <= 2'b00;
      r_mem_rd  <= 1'b0;
      r_ca_di   <= 16'hFFFF;
      r_ld_di   <= 16'hFFFF;
      r_ca_rdy  <= 1'b0;
      r_ld_rdy  <= 1'b0;
      r_to_err  <= 1'b0;
    end else begin
      r_ca_rdy <= 1'b0;
      r_ld_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_ca) begin
            r_mem_a   <= CA_A;
            r_mem_do  <= CA_DO;
            r_mem_we  <= CA_WE;
            r_mem_rd  <= CA_RD & ~(|CA_WE);
            r_is_rd   <= ~(|CA_WE);
            r_last_ld <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_GNT_CA;
          end else if (w_grant_ld) begin
            r_mem_a   <= LD_A;
            r_mem_do  <= LD_DO;
            r_mem_we  <= LD_WE;
            r_mem_rd  <= LD_RD & ~(|LD_WE);
            r_is_rd   <= ~(|LD_WE);
            r_last_ld <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_GNT_LD;
          end
        end

        S_GNT_CA, S_GNT_LD: begin
          if (MEM_RDY || w_timeout) begin
            r_mem_rd <= 1'b0;
            r_mem_we <= 2'b00;
            if (r_state == S_GNT_CA) begin
              r_ca_rdy <= 1'b1;
              if (r_is_rd) r_ca_di <= w_rd_data;
            end else begin
              r_ld_rdy <= 1'b1;
              if (r_is_rd) r_ld_di <= w_rd_data;
            end
            if (!MEM_RDY) r_to_err <= 1'b1;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        // One dead cycle so requesters can drop their request after RDY.
        S_GAP: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign MEM_A  = r_mem_a;
  assign MEM_DO = r_mem_do;
  assign MEM_WE = r_mem_we;
  assign MEM_RD = r_mem_rd;
  assign CA_DI  = r_ca_di;
  assign CA_RDY = r_ca_rdy;
  assign LD_DI  = r_ld_di;
  assign LD_RDY = r_ld_rdy;
  assign TO_ERR = r_to_err;

endmodule
